// File: rtl/tmds_serializer_array.sv
// ---------------------------------------------------------------------------
// tmds_serializer_array
//
// Multi-lane parallel-to-serial converter for the TMDS output path. Every
// PHASES = WORD_WIDTH/BITS_PER_CLK clocks one WORD_WIDTH-bit word per lane is
// loaded into that lane's shift buffer. BITS_PER_CLK bits per lane are then
// presented each clock to the DDR/OSERDES primitives. All lanes share one
// phase counter, so they stay word-aligned with each other.
//
// Ports:
//   clk_tmds_half  in   serializer clock (bit rate / BITS_PER_CLK)
//   reset_n        in   asynchronous active-low reset
//   enable         in   1 = accept data, 0 = send IDLE_WORD continuously
//   in             in   lane c word at [c*WORD_WIDTH +: WORD_WIDTH]
//   in_valid       in   in holds a valid word set (all lanes together)
//   realign        in   one-cycle pulse: make the next edge a load edge
//   underrun_clr   in   clears the sticky underrun flag
//   word_req       out  load cycle; in/in_valid are sampled at this edge
//   out            out  lane c bits at [c*BITS_PER_CLK +: BITS_PER_CLK],
//                       bit k is the k-th bit in time within the clock
//   underrun       out  sticky: a load happened with enable=1, in_valid=0
// ---------------------------------------------------------------------------
module tmds_serializer_array #(
    parameter int                    CHANNELS     = 3,
    parameter int                    WORD_WIDTH   = 10,
    parameter int                    BITS_PER_CLK = 2,
    parameter int                    MSB_FIRST    = 0,
    parameter logic [WORD_WIDTH-1:0] IDLE_WORD    = 10'b1101010100
) (
    input  logic                             clk_tmds_half,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic [CHANNELS*WORD_WIDTH-1:0]   in,
    input  logic                             in_valid,
    input  logic                             realign,
    input  logic                             underrun_clr,
    output logic                             word_req,
    output logic [CHANNELS*BITS_PER_CLK-1:0] out,
    output logic                             underrun
);

    localparam int PHASES = WORD_WIDTH / BITS_PER_CLK;
    // Keep the counter at least one bit wide even when PHASES == 1.
    localparam int PH_W   = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(PHASES - 1);

    if ((WORD_WIDTH % BITS_PER_CLK) != 0) begin : g_bad_cfg
        $error("tmds_serializer_array: BITS_PER_CLK must divide WORD_WIDTH");
    end

    logic [PH_W-1:0]       r_phase;
    logic [WORD_WIDTH-1:0] r_buf [CHANNELS];
    logic                  r_underrun;
    logic                  w_load;
    logic                  w_take_data;

    assign w_load      = (r_phase == LAST_PHASE);
    assign w_take_data = enable && in_valid;

    // word_req is purely combinational so the source sees the request in
    // the same cycle whose closing edge samples in/in_valid.
    assign word_req = w_load && enable;
    assign underrun = r_underrun;

    // Phase counter: free-running, independent of enable. realign forces
    // the last phase so the very next edge loads, truncating the word in
    // flight (and, if this edge already loads, loading again next edge).
    always_ff @(posedge clk_tmds_half or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
        end else if (realign) begin
            r_phase <= LAST_PHASE;
        end else if (w_load) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + PH_W'(1);
        end
    end

    // Sticky underrun: a starved load takes priority over a clear in the
    // same cycle, so no underrun event can be lost.
    always_ff @(posedge clk_tmds_half or negedge reset_n) begin
        if (!reset_n) begin
            r_underrun <= 1'b0;
        end else if (w_load && enable && !in_valid) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

    // Shift buffers: load on the last phase, otherwise shift toward the
    // output end with zero fill.
    always_ff @(posedge clk_tmds_half or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_buf[c] <= '0;
            end
        end else if (w_load) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_buf[c] <= w_take_data ? in[c*WORD_WIDTH +: WORD_WIDTH] : IDLE_WORD;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (MSB_FIRST != 0) begin
                    r_buf[c] <= r_buf[c] << BITS_PER_CLK;
                end else begin
                    r_buf[c] <= r_buf[c] >> BITS_PER_CLK;
                end
            end
        end
    end

    // Outputs come straight from the buffer registers; there is no path
    // from in to out that bypasses a flop.
    always_comb begin
        out = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int k = 0; k < BITS_PER_CLK; k++) begin
                if (MSB_FIRST != 0) begin
                    out[c*BITS_PER_CLK + k] = r_buf[c][WORD_WIDTH-1-k];
                end else begin
                    out[c*BITS_PER_CLK + k] = r_buf[c][k];
                end
            end
        end
    end

endmodule

// File: doc/tmds_serializer_array.md
Name: tmds_serializer_array

Overview:
- Multi-channel, parametrised parallel-to-serial converter for the HDMI/TMDS output path.
- Takes one WORD_WIDTH-bit encoded word per channel every PHASES = WORD_WIDTH/BITS_PER_CLK clocks.
- Emits BITS_PER_CLK bits per channel per clock to the DDR/OSERDES output primitives.
- Adds over a single-channel serializer:
  - valid/request handshake
  - idle-word substitution with sticky underrun flag
  - selectable bit order
  - synchronous phase realignment

Parameters:
CHANNELS, 3, number of independent serial lanes (TMDS data channels).
WORD_WIDTH, 10, bits per parallel word.
BITS_PER_CLK, 2, bits emitted per channel per clock (2 = DDR at half bit rate); must divide WORD_WIDTH, elaboration error otherwise.
MSB_FIRST, 0, 0 = bit 0 of word transmitted first; 1 = bit WORD_WIDTH-1 first.
IDLE_WORD, 10'b1101010100, word loaded on every channel when no valid data (TMDS control 00).

Ports:
clk_tmds_half  in   1  serializer clock (bit rate / BITS_PER_CLK).
reset_n        in   1  asynchronous active-low reset.
enable         in   1  1 = accept data; 0 = transmit IDLE_WORD continuously.
in             in   CHANNELS*WORD_WIDTH  channel c word at [c*WORD_WIDTH +: WORD_WIDTH].
in_valid       in   1  in holds a valid word set (all channels together).
realign        in   1  single-cycle pulse: restart word framing.
underrun_clr   in   1  clears underrun flag.
word_req       out  1  load cycle; in/in_valid sampled at this clock's rising edge.
out            out  CHANNELS*BITS_PER_CLK  channel c bits at [c*BITS_PER_CLK +: BITS_PER_CLK]; bit k = k-th bit in time within the clock.
underrun       out  1  sticky: a load occurred with enable=1 and in_valid=0.

Behaviour:
- Reset state (async, reset_n=0):
  - phase = 0, all shift buffers = 0, underrun = 0.
  - out = 0, word_req = 0.
- Phase counter runs 0..PHASES-1, then wraps to 0; runs regardless of enable.
- word_req:
  - Combinational: (phase == PHASES-1) && enable.
  - No registered delay.
- Load edge (rising edge with phase == PHASES-1), per channel buffer:
  - enable=1, in_valid=1: buffer <= channel word from in.
  - enable=1, in_valid=0: buffer <= IDLE_WORD; underrun <= 1.
  - enable=0: buffer <= IDLE_WORD; underrun unchanged; in ignored.
- Non-load edge:
  - MSB_FIRST=0: buffer shifts right by BITS_PER_CLK, zero fill.
  - MSB_FIRST=1: buffer shifts left by BITS_PER_CLK, zero fill.
- out is driven directly from buffer registers (no combinational path from in):
  - MSB_FIRST=0: bit k = buffer[k].
  - MSB_FIRST=1: bit k = buffer[WORD_WIDTH-1-k].
- Latency: a word sampled at load edge N appears on out in the cycle after edge N. It occupies PHASES consecutive cycles, back-to-back, with no gap cycles.
- realign=1 at an edge:
  - phase <= PHASES-1, so the next edge is a load edge.
  - Buffer shifts or loads normally at that edge; the in-flight word is truncated.
  - If realign is asserted on a load edge, the load still happens and the following edge loads again.
- underrun_clr:
  - Clears underrun to 0.
  - Set wins if underrun_clr and an underrun load coincide.
- All channels share phase; words are loaded simultaneously, so lanes stay mutually aligned.
- reset_n assertion mid-word aborts immediately. After deassertion, the first load occurs at the PHASES-th rising edge.

Test Plan:
- Defaults, enable=1, in_valid=1 held:
  - word_req is high on the 5th edge after reset release and on every 5th edge after.
  - Out stays 0 until the first load.
- Defaults, ch0 = 10'h2AB loaded: ch0 out over 5 cycles = 2'b11, 2'b10, 2'b10, 2'b10, 2'b10. Channels 1/2 with 10'h155 / 10'h3FF simultaneously:
  - ch1 = 2'b01 x5.
  - ch2 = 2'b11 x5.
  - All three start in the same cycle.
- Underrun: in_valid=0 at a load edge:
  - Every channel emits IDLE_WORD = 2'b00, 2'b01, 2'b01, 2'b01, 2'b11.
  - underrun goes 1 and stays 1 until an underrun_clr pulse.
  - A coincident clr + underrun leaves underrun=1.
- enable=0: output is the continuous IDLE_WORD pattern, word_req stays 0, underrun never set, and in toggling has no effect.
- MSB_FIRST=1, ch0 = 10'h2AB: out = 2'b01, 2'b01, 2'b01, 2'b01, 2'b11.
- realign at phase 1:
  - Load occurs at the next edge and the word cycle restarts there.
  - reset_n pulsed mid-word: out = 0 immediately (asynchronous), and the first post-reset load follows 5 edges later.
